plru_replacement_unit: RTL and testbench

- Per-set tree pseudo-LRU replacement state for the set-associative L2. Sits directly downstream of the tag-compare/hit stage.
- Consumes the lookup result for one set per cycle: hit flag, encoded hit way and the set's valid bits.
- On a hit it updates recency. On a miss it selects the victim way for the fill path.
- Holds one (ways-1)-bit tree per set in internal storage, with a read-modify-write pipeline and same-index bypass.

---
 rtl/plru_replacement_unit.sv | 158 +++++++++++++++
 tb/tb_plru_replacement_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/plru_replacement_unit.sv
// Tree pseudo-LRU replacement state for a set-associative cache.
// One (ways-1)-bit tree per set. Each request reads its set's tree in the
// cycle it is accepted, computes the victim and the updated tree in that same
// cycle, and registers both. The updated tree is written back one cycle later,
// and a same-index bypass covers that write-back window.
module plru_replacement_unit #(
    parameter int indexBits = 14,
    parameter int ways      = 8
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    reqValid,
    output logic                    reqReady,
    input  logic [indexBits-1:0]    reqIndex,
    input  logic                    reqHit,
    input  logic [$clog2(ways)-1:0] reqHitWay,
    input  logic [ways-1:0]         reqValidBits,
    input  logic                    flushAll,
    output logic                    victimValid,
    output logic [$clog2(ways)-1:0] victimWay
);

    localparam int WAY_BITS = $clog2(ways);
    localparam int NODES    = ways - 1;
    localparam int SETS     = 2 ** indexBits;
    localparam logic [indexBits-1:0] SWEEP_LAST = '1;

    typedef enum logic {
        ST_SWEEP,
        ST_RUN
    } state_t;

    state_t                state_q;
    state_t                state_next;
    logic [indexBits-1:0]  sweep_cnt;

    logic [NODES-1:0]      tree_mem [SETS];

    logic                  accept;
    logic [NODES-1:0]      cur_tree;
    logic [WAY_BITS-1:0]   walk_way;
    logic [WAY_BITS-1:0]   walk_node;
    logic [WAY_BITS-1:0]   inv_way;
    logic                  inv_found;
    logic [ways-1:0]       inv_scan;
    logic [WAY_BITS-1:0]   access_way;
    logic [WAY_BITS-1:0]   upd_node;
    logic [WAY_BITS-1:0]   upd_path;
    logic [NODES-1:0]      new_tree;

    logic                  s2_valid;
    logic [indexBits-1:0]  s2_index;
    logic [NODES-1:0]      s2_tree;

    assign accept = reqValid & reqReady;

    // State register: reset always lands in a clear sweep.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= ST_SWEEP;
        else          state_q <= state_next;
    end

    // Next state: sweep ends on the last index; a flush only starts a sweep from run.
    // NOTE: combinational blocks assign a default first so no latch is inferred.
    always_comb begin
        state_next = state_q;
        case (state_q)
            ST_SWEEP: if (sweep_cnt == SWEEP_LAST) state_next = ST_RUN;
            ST_RUN:   if (flushAll)                state_next = ST_SWEEP;
            default:  state_next = ST_SWEEP;
        endcase
    end

    // Outputs of the FSM: requests are accepted only outside a sweep.
    always_comb begin
        reqReady = (state_q == ST_RUN);
    end

    // Sweep counter: walks every index during a sweep, rearmed to 0 on flush.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                          sweep_cnt <= '0;
        else if (state_q == ST_SWEEP)          sweep_cnt <= sweep_cnt + 1'b1;
        else if (flushAll)                     sweep_cnt <= '0;
    end

    // Tree read with bypass from the pending write-back of the previous request.
    always_comb begin
        if (s2_valid && (s2_index == reqIndex)) cur_tree = s2_tree;
        else                                    cur_tree = tree_mem[reqIndex];
    end

    // PLRU walk from the root, following each node bit toward the victim.
    always_comb begin
        walk_way  = '0;
        walk_node = '0;
        for (int lvl = 0; lvl < WAY_BITS; lvl++) begin
            walk_way  = (walk_way << 1) | WAY_BITS'(cur_tree[walk_node]);
            walk_node = (walk_node << 1) + WAY_BITS'(1) + WAY_BITS'(cur_tree[walk_node]);
        end
    end

    // Lowest-numbered invalid way, scanned from way 0 upward.
    always_comb begin
        inv_way   = '0;
        inv_found = 1'b0;
        inv_scan  = reqValidBits;
        for (int w = 0; w < ways; w++) begin
            if (!inv_found && !inv_scan[0]) begin
                inv_way   = WAY_BITS'(w);
                inv_found = 1'b1;
            end
            inv_scan = inv_scan >> 1;
        end
    end

    // Access update: every node on the accessed way's path points away from it.
    always_comb begin
        if (reqHit)         access_way = reqHitWay;
        else if (inv_found) access_way = inv_way;
        else                access_way = walk_way;
        new_tree = cur_tree;
        upd_node = '0;
        upd_path = access_way;
        for (int lvl = 0; lvl < WAY_BITS; lvl++) begin
            new_tree[upd_node] = ~upd_path[WAY_BITS-1];
            upd_node = (upd_node << 1) + WAY_BITS'(1) + WAY_BITS'(upd_path[WAY_BITS-1]);
            upd_path = upd_path << 1;
        end
    end

    // Stage 2 and registered victim outputs; victim pulses only on an accepted miss.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid    <= 1'b0;
            s2_index    <= '0;
            s2_tree     <= '0;
            victimValid <= 1'b0;
            victimWay   <= '0;
        end else begin
            s2_valid    <= accept;
            victimValid <= accept & ~reqHit;
            if (accept) begin
                s2_index <= reqIndex;
                s2_tree  <= new_tree;
            end
            if (accept && !reqHit) victimWay <= access_way;
        end
    end

    // Tree storage write port: the sweep has priority, otherwise stage-2 write-back.
    // NOTE: the array has no reset; the post-reset sweep clears it instead.
    always_ff @(posedge clock) begin
        if (state_q == ST_SWEEP) tree_mem[sweep_cnt] <= '0;
        else if (s2_valid)       tree_mem[s2_index]  <= s2_tree;
    end

endmodule

// File: tb/tb_plru_replacement_unit.sv
// Directed bench for plru_replacement_unit with ways=8 and indexBits=2.
// A table of back-to-back requests with hand-computed victims, followed by
// hand-written flush and reset sequences that measure the sweep length.
module tb_plru_replacement_unit;

    localparam int IB = 2;
    localparam int W  = 8;
    localparam int WB = 3;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          reqValid;
    logic          reqReady;
    logic [IB-1:0] reqIndex;
    logic          reqHit;
    logic [WB-1:0] reqHitWay;
    logic [W-1:0]  reqValidBits;
    logic          flushAll;
    logic          victimValid;
    logic [WB-1:0] victimWay;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string         name;
        logic          valid;
        logic [IB-1:0] idx;
        logic          hit;
        logic [WB-1:0] hway;
        logic [W-1:0]  vbits;
        logic          exp_vv;
        logic [WB-1:0] exp_way;
    } vec_t;

    vec_t vecs[$];

    plru_replacement_unit #(.indexBits(IB), .ways(W)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .reqValid     (reqValid),
        .reqReady     (reqReady),
        .reqIndex     (reqIndex),
        .reqHit       (reqHit),
        .reqHitWay    (reqHitWay),
        .reqValidBits (reqValidBits),
        .flushAll     (flushAll),
        .victimValid  (victimValid),
        .victimWay    (victimWay)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic void add(input string nm, input logic v, input int idx, input logic h,
                                input int hw, input logic [W-1:0] vb, input logic ev, input int ew);
        vec_t r;
        r.name    = nm;
        r.valid   = v;
        r.idx     = IB'(idx);
        r.hit     = h;
        r.hway    = WB'(hw);
        r.vbits   = vb;
        r.exp_vv  = ev;
        r.exp_way = WB'(ew);
        vecs.push_back(r);
    endfunction

    // Drive one request, advance one clock, check the registered victim outputs.
    task automatic run_one(input vec_t v);
        reqValid     = v.valid;
        reqIndex     = v.idx;
        reqHit       = v.hit;
        reqHitWay    = v.hway;
        reqValidBits = v.vbits;
        @(posedge clock);
        #1;
        check({v.name, " victimValid"}, 32'(victimValid), 32'(v.exp_vv));
        if (v.exp_vv) check({v.name, " victimWay"}, 32'(victimWay), 32'(v.exp_way));
    endtask

    // Count clocks until reqReady rises; victimValid must stay low throughout.
    task automatic measure_sweep(input string name);
        int n = 0;
        while (reqReady !== 1'b1 && n < 50) begin
            @(posedge clock);
            #1;
            n++;
            check({name, " no victim during sweep"}, 32'(victimValid), 32'd0);
        end
        check({name, " length"}, 32'(n), 32'd4);
    endtask

    function automatic vec_t mk(input string nm, input int idx, input logic h, input int hw,
                                input logic [W-1:0] vb, input logic ev, input int ew);
        vec_t r;
        r.name    = nm;
        r.valid   = 1'b1;
        r.idx     = IB'(idx);
        r.hit     = h;
        r.hway    = WB'(hw);
        r.vbits   = vb;
        r.exp_vv  = ev;
        r.exp_way = WB'(ew);
        return r;
    endfunction

    initial begin
        // First access after reset: all trees zero.
        add("idx1 first miss", 1, 1, 0, 0, 8'hFF, 1, 0);
        // Eight back-to-back misses to one index, then the cycle restarts.
        add("idx2 miss a", 1, 2, 0, 0, 8'hFF, 1, 0);
        add("idx2 miss b", 1, 2, 0, 0, 8'hFF, 1, 4);
        add("idx2 miss c", 1, 2, 0, 0, 8'hFF, 1, 2);
        add("idx2 miss d", 1, 2, 0, 0, 8'hFF, 1, 6);
        add("idx2 miss e", 1, 2, 0, 0, 8'hFF, 1, 1);
        add("idx2 miss f", 1, 2, 0, 0, 8'hFF, 1, 5);
        add("idx2 miss g", 1, 2, 0, 0, 8'hFF, 1, 3);
        add("idx2 miss h", 1, 2, 0, 0, 8'hFF, 1, 7);
        add("idx2 miss ninth", 1, 2, 0, 0, 8'hFF, 1, 0);
        add("idle cycle", 0, 0, 0, 0, 8'hFF, 0, 0);
        // Index 3: touch ways 0 and 4, fill invalid way 2, then walk lands on 6.
        add("idx3 miss a", 1, 3, 0, 0, 8'hFF, 1, 0);
        add("idx3 miss b", 1, 3, 0, 0, 8'hFF, 1, 4);
        add("idx3 invalid way", 1, 3, 0, 0, 8'hFB, 1, 2);
        add("idx3 after invalid", 1, 3, 0, 0, 8'hFF, 1, 6);
        // Index 0: hits steer the tree; the hit on 4 ignores the valid bits.
        add("idx0 hit 0", 1, 0, 1, 0, 8'hFF, 0, 0);
        add("idx0 miss after hit", 1, 0, 0, 0, 8'hFF, 1, 4);
        add("idx0 hit 4", 1, 0, 1, 4, 8'h00, 0, 0);
        add("idx0 miss after hit 4", 1, 0, 0, 0, 8'hFF, 1, 2);
        // Interleaved indices: each keeps its own tree.
        add("mixed idx1", 1, 1, 0, 0, 8'hFF, 1, 4);
        add("mixed idx2", 1, 2, 0, 0, 8'hFF, 1, 4);
        add("mixed idx1 again", 1, 1, 0, 0, 8'hFF, 1, 2);
        add("mixed idx2 again", 1, 2, 0, 0, 8'hFF, 1, 2);
        add("mixed idx0", 1, 0, 0, 0, 8'hFF, 1, 6);

        reset_n      = 1'b0;
        reqValid     = 1'b0;
        reqIndex     = '0;
        reqHit       = 1'b0;
        reqHitWay    = '0;
        reqValidBits = '1;
        flushAll     = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset victimValid", 32'(victimValid), 32'd0);
        check("reset victimWay", 32'(victimWay), 32'd0);
        check("reset reqReady", 32'(reqReady), 32'd0);

        // Requests offered during the power-up sweep are ignored.
        reset_n  = 1'b1;
        reqValid = 1'b1;
        reqIndex = 2'd1;
        measure_sweep("reset sweep");
        reqValid = 1'b0;

        for (int i = 0; i < vecs.size(); i++) run_one(vecs[i]);
        reqValid = 1'b0;

        // Flush held high for the whole sweep: only the first sample counts.
        flushAll = 1'b1;
        @(posedge clock);
        #1;
        check("flush reqReady low", 32'(reqReady), 32'd0);
        reqValid     = 1'b1;
        reqIndex     = 2'd2;
        reqHit       = 1'b0;
        reqValidBits = '1;
        measure_sweep("flush sweep");
        flushAll = 1'b0;
        reqValid = 1'b0;
        run_one(mk("idx2 after flush", 2, 0, 0, 8'hFF, 1, 0));
        reqValid = 1'b0;

        // Request accepted together with flush still produces its victim.
        reqValid     = 1'b1;
        reqIndex     = 2'd2;
        reqHit       = 1'b0;
        reqValidBits = '1;
        flushAll     = 1'b1;
        @(posedge clock);
        #1;
        flushAll = 1'b0;
        reqValid = 1'b0;
        check("flush+req victimValid", 32'(victimValid), 32'd1);
        check("flush+req victimWay", 32'(victimWay), 32'd4);
        check("flush+req reqReady low", 32'(reqReady), 32'd0);
        measure_sweep("flush+req sweep");

        // Reset in the middle of a sweep restarts it from index 0.
        flushAll = 1'b1;
        @(posedge clock);
        #1;
        flushAll = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        #2;
        check("mid-sweep reset victimValid", 32'(victimValid), 32'd0);
        check("mid-sweep reset victimWay", 32'(victimWay), 32'd0);
        check("mid-sweep reset reqReady", 32'(reqReady), 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        measure_sweep("mid-sweep reset sweep");
        run_one(mk("idx2 after reset", 2, 0, 0, 8'hFF, 1, 0));
        run_one(mk("idx1 after reset", 1, 0, 0, 8'hFF, 1, 0));
        reqValid = 1'b0;
        @(posedge clock);
        #1;
        check("final idle victimValid", 32'(victimValid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
